branch_resolve_unit: RTL and testbench

Parametrised, pipelined successor to the combinational branch comparator. Evaluates all six RV32I/RV64I conditional-branch conditions, computes the branch target, checks it against the fetch-stage prediction and presents a registered resolution (taken, redirect PC, mispredict) to the PC-select logic. Sits between the register-read/execute stage and the front end, with a valid/ready handshake on both sides, a flush input and saturating performance counters.

---
 rtl/branch_resolve_unit_pkg.sv | 21 ++
 rtl/branch_resolve_unit_if.sv | 36 +++
 rtl/branch_resolve_unit_cond_eval.sv | 38 +++
 rtl/branch_resolve_unit.sv | 97 +++++++++
 tb/tb_branch_resolve_unit.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/branch_resolve_unit_pkg.sv
// Shared branch definitions: funct3 encodings, the illegal-funct3 predicate
// and the default datapath width used by the branch resolution logic.
package branch_pkg;

  localparam int XLEN_DEFAULT = 32;

  typedef enum logic [2:0] {
    F3_BEQ  = 3'b000,
    F3_BNE  = 3'b001,
    F3_BLT  = 3'b100,
    F3_BGE  = 3'b101,
    F3_BLTU = 3'b110,
    F3_BGEU = 3'b111
  } branch_f3_e;

  // 010 and 011 are the only holes in the conditional-branch funct3 space.
  function automatic logic is_illegal_f3(input logic [2:0] f3);
    return (f3 == 3'b010) || (f3 == 3'b011);
  endfunction

endpackage

// File: rtl/branch_resolve_unit_if.sv
// Producer/consumer bundle of the branch resolution unit: execute-side
// request channel and front-end-side resolution channel.
interface branch_resolve_unit_if #(
  parameter int XLEN = 32
);
  logic            in_valid;
  logic            in_ready;
  logic [2:0]      in_funct3;
  logic [XLEN-1:0] in_rs1;
  logic [XLEN-1:0] in_rs2;
  logic [XLEN-1:0] in_pc;
  logic [XLEN-1:0] in_imm;
  logic            in_pred_taken;
  logic [XLEN-1:0] in_pred_target;

  logic            out_valid;
  logic            out_ready;
  logic            out_taken;
  logic [XLEN-1:0] out_redirect_pc;
  logic            out_mispredict;
  logic            out_illegal;

  modport master (
    output in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm,
           in_pred_taken, in_pred_target, out_ready,
    input  in_ready, out_valid, out_taken, out_redirect_pc,
           out_mispredict, out_illegal
  );

  modport slave (
    input  in_valid, in_funct3, in_rs1, in_rs2, in_pc, in_imm,
           in_pred_taken, in_pred_target, out_ready,
    output in_ready, out_valid, out_taken, out_redirect_pc,
           out_mispredict, out_illegal
  );
endinterface

// File: rtl/branch_resolve_unit_cond_eval.sv
// Purely combinational branch condition evaluator; shared with other
// execute-stage variants, so it carries no state and no handshake.
module branch_cond_eval
  import branch_pkg::*;
#(
  parameter int XLEN = XLEN_DEFAULT
) (
  input  logic [2:0]      funct3,
  input  logic [XLEN-1:0] rs1,
  input  logic [XLEN-1:0] rs2,
  output logic            taken,
  output logic            illegal
);

  logic eq;
  logic lt;
  logic ltu;

  assign eq  = (rs1 == rs2);
  assign lt  = ($signed(rs1) < $signed(rs2));
  assign ltu = (rs1 < rs2);

  // Illegal encodings fall into the default arm, so they never report taken.
  always_comb begin
    taken   = 1'b0;
    illegal = is_illegal_f3(funct3);
    case (funct3)
      F3_BEQ:  taken = eq;
      F3_BNE:  taken = !eq;
      F3_BLT:  taken = lt;
      F3_BGE:  taken = !lt;
      F3_BLTU: taken = ltu;
      F3_BGEU: taken = !ltu;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/branch_resolve_unit.sv
// Pipelined branch resolution: evaluates the condition, computes the target,
// checks the fetch prediction and holds one registered result for the front end.
module branch_resolve_unit
  import branch_pkg::*;
#(
  parameter int XLEN  = XLEN_DEFAULT,
  parameter int CNT_W = 32
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  flush,
  branch_resolve_unit_if.slave  bus,
  output logic [CNT_W-1:0]      branch_count,
  output logic [CNT_W-1:0]      mispredict_count
);

  logic [XLEN-1:0] target;
  logic [XLEN-1:0] fallthrough;
  logic            cond_taken;
  logic            cond_illegal;
  logic            mispredict_next;
  logic            load;
  logic            retire;

  logic            valid_q;
  logic            taken_q;
  logic            mispredict_q;
  logic            illegal_q;
  logic [XLEN-1:0] redirect_q;

  branch_cond_eval #(.XLEN(XLEN)) u_cond (
    .funct3  (bus.in_funct3),
    .rs1     (bus.in_rs1),
    .rs2     (bus.in_rs2),
    .taken   (cond_taken),
    .illegal (cond_illegal)
  );

  assign target          = bus.in_pc + bus.in_imm;
  assign fallthrough     = bus.in_pc + XLEN'(4);
  assign mispredict_next = !cond_illegal &&
                           ((cond_taken != bus.in_pred_taken) ||
                            (cond_taken && (bus.in_pred_target != target)));

  // Flush beats both a new load and a retiring handshake in the same cycle.
  assign bus.in_ready = !valid_q || bus.out_ready;
  assign load         = bus.in_valid && bus.in_ready && !flush;
  assign retire       = valid_q && bus.out_ready && !flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
    end else if (flush) begin
      valid_q <= 1'b0;
    end else if (load) begin
      valid_q <= 1'b1;
    end else if (retire) begin
      valid_q <= 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      taken_q      <= 1'b0;
      mispredict_q <= 1'b0;
      illegal_q    <= 1'b0;
      redirect_q   <= '0;
    end else if (load) begin
      taken_q      <= cond_taken;
      mispredict_q <= mispredict_next;
      illegal_q    <= cond_illegal;
      redirect_q   <= cond_taken ? target : fallthrough;
    end
  end

  // Counters only move when a result actually leaves the unit, and stick at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      branch_count     <= '0;
      mispredict_count <= '0;
    end else if (retire) begin
      if (!illegal_q && (branch_count != '1)) begin
        branch_count <= branch_count + CNT_W'(1);
      end
      if (mispredict_q && (mispredict_count != '1)) begin
        mispredict_count <= mispredict_count + CNT_W'(1);
      end
    end
  end

  assign bus.out_valid       = valid_q;
  assign bus.out_taken       = taken_q;
  assign bus.out_mispredict  = mispredict_q;
  assign bus.out_illegal     = illegal_q;
  assign bus.out_redirect_pc = redirect_q;

endmodule

// File: tb/tb_branch_resolve_unit.sv
// Scoreboard bench for branch_resolve_unit: directed branches push expected
// resolutions, an independent monitor pops and compares on every output handshake.
module tb_branch_resolve_unit;

  typedef struct packed {
    logic        taken;
    logic [31:0] redirect;
    logic        mispredict;
    logic        illegal;
  } exp_t;

  logic clk = 1'b0;
  logic rst_n;
  logic flush;
  logic flush4;
  logic [31:0] branch_count;
  logic [31:0] mispredict_count;
  logic [3:0]  branch_count4;
  logic [3:0]  mispredict_count4;

  exp_t sb[$];
  int   compared   = 0;
  int   mismatched = 0;

  always #5 clk = ~clk;

  branch_resolve_unit_if #(.XLEN(32)) bus ();
  branch_resolve_unit_if #(.XLEN(32)) bus4 ();

  branch_resolve_unit #(.XLEN(32), .CNT_W(32)) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush),
    .bus              (bus.slave),
    .branch_count     (branch_count),
    .mispredict_count (mispredict_count)
  );

  // Narrow-counter instance used only to exercise saturation.
  branch_resolve_unit #(.XLEN(32), .CNT_W(4)) dut4 (
    .clk              (clk),
    .rst_n            (rst_n),
    .flush            (flush4),
    .bus              (bus4.slave),
    .branch_count     (branch_count4),
    .mispredict_count (mispredict_count4)
  );

  task automatic checkValue(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic checkOutput();
    exp_t e;
    if (sb.size() == 0) begin
      compared++;
      mismatched++;
      $display("[TB] FAIL unexpected_output: got redirect 0x%0h, expected no output", bus.out_redirect_pc);
    end else begin
      e = sb.pop_front();
      checkValue("out_taken", 64'(bus.out_taken), 64'(e.taken));
      checkValue("out_redirect_pc", 64'(bus.out_redirect_pc), 64'(e.redirect));
      checkValue("out_mispredict", 64'(bus.out_mispredict), 64'(e.mispredict));
      checkValue("out_illegal", 64'(bus.out_illegal), 64'(e.illegal));
    end
  endtask

  // Monitor samples late in the low phase, after all bench drives have settled.
  always @(negedge clk) begin
    #3;
    if (rst_n && bus.out_valid && bus.out_ready && !flush) checkOutput();
  end

  task automatic applyStimulus(input logic [2:0] f3, input logic [31:0] rs1, input logic [31:0] rs2,
                               input logic [31:0] pc, input logic [31:0] imm, input logic pt,
                               input logic [31:0] ptgt, input logic et, input logic [31:0] ered,
                               input logic emis, input logic eill);
    int   n = 0;
    exp_t e;
    @(negedge clk);
    #1;
    bus.in_funct3      = f3;
    bus.in_rs1         = rs1;
    bus.in_rs2         = rs2;
    bus.in_pc          = pc;
    bus.in_imm         = imm;
    bus.in_pred_taken  = pt;
    bus.in_pred_target = ptgt;
    bus.in_valid       = 1'b1;
    #1;
    while (!bus.in_ready && n < 20) begin
      @(negedge clk);
      #2;
      n++;
    end
    if (!bus.in_ready) begin
      checkValue("accept_timeout", 64'(bus.in_ready), 64'd1);
    end else begin
      e.taken      = et;
      e.redirect   = ered;
      e.mispredict = emis;
      e.illegal    = eill;
      sb.push_back(e);
    end
  endtask

  task automatic idle();
    @(negedge clk);
    #1;
    bus.in_valid = 1'b0;
  endtask

  task automatic checkCounts(input logic [31:0] eb, input logic [31:0] em);
    checkValue("branch_count", 64'(branch_count), 64'(eb));
    checkValue("mispredict_count", 64'(mispredict_count), 64'(em));
  endtask

  initial begin
    rst_n = 1'b0;
    flush = 1'b0;
    flush4 = 1'b0;
    bus.in_valid = 1'b0; bus.in_funct3 = '0; bus.in_rs1 = '0; bus.in_rs2 = '0;
    bus.in_pc = '0; bus.in_imm = '0; bus.in_pred_taken = 1'b0; bus.in_pred_target = '0;
    bus.out_ready = 1'b0;
    bus4.in_valid = 1'b0; bus4.in_funct3 = 3'b100; bus4.in_rs1 = 32'hFFFF_FFFF; bus4.in_rs2 = 32'd1;
    bus4.in_pc = 32'h100; bus4.in_imm = 32'h20; bus4.in_pred_taken = 1'b0; bus4.in_pred_target = '0;
    bus4.out_ready = 1'b0;

    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    checkValue("reset_out_valid", 64'(bus.out_valid), 64'd0);
    checkValue("reset_out_taken", 64'(bus.out_taken), 64'd0);
    checkValue("reset_out_mispredict", 64'(bus.out_mispredict), 64'd0);
    checkValue("reset_out_illegal", 64'(bus.out_illegal), 64'd0);
    checkValue("reset_redirect", 64'(bus.out_redirect_pc), 64'd0);
    checkValue("reset_in_ready", 64'(bus.in_ready), 64'd1);
    checkCounts(32'd0, 32'd0);
    #1 bus.out_ready = 1'b1;

    // BLT -1 < 1 taken, predicted not-taken.
    applyStimulus(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 32'h0, 1'b1, 32'h120, 1'b1, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    checkCounts(32'd1, 32'd1);

    // BLTU, BEQ with wrong target, BEQ with wrapping target, back to back.
    applyStimulus(3'b110, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 32'h0, 1'b0, 32'h104, 1'b0, 1'b0);
    applyStimulus(3'b000, 32'd5, 32'd5, 32'h100, 32'h20, 1'b1, 32'h124, 1'b1, 32'h120, 1'b1, 1'b0);
    applyStimulus(3'b000, 32'd5, 32'd5, 32'hFFFF_FFF0, 32'h20, 1'b1, 32'h10, 1'b1, 32'h10, 1'b0, 1'b0);
    idle();
    repeat (2) @(negedge clk);
    checkCounts(32'd4, 32'd2);

    // Illegal funct3 010 is not counted.
    applyStimulus(3'b010, 32'd1, 32'd1, 32'h200, 32'h40, 1'b1, 32'h0, 1'b0, 32'h204, 1'b0, 1'b1);
    idle();
    repeat (2) @(negedge clk);
    checkCounts(32'd4, 32'd2);

    // BNE backward, BGE signed, BGEU unsigned, illegal 011 with wrapping fallthrough.
    applyStimulus(3'b001, 32'd3, 32'd4, 32'h300, 32'hFFFF_FFF0, 1'b1, 32'h2F0, 1'b1, 32'h2F0, 1'b0, 1'b0);
    applyStimulus(3'b101, 32'd1, 32'hFFFF_FFFF, 32'h400, 32'h8, 1'b0, 32'h0, 1'b1, 32'h408, 1'b1, 1'b0);
    applyStimulus(3'b111, 32'd1, 32'hFFFF_FFFF, 32'h400, 32'h8, 1'b1, 32'h408, 1'b0, 32'h404, 1'b1, 1'b0);
    applyStimulus(3'b011, 32'd0, 32'd0, 32'hFFFF_FFFC, 32'h8, 1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 1'b1);
    idle();
    repeat (2) @(negedge clk);
    checkCounts(32'd7, 32'd4);

    // Stall: consumer holds off three cycles while the next branch waits.
    @(negedge clk);
    #1 bus.out_ready = 1'b0;
    applyStimulus(3'b001, 32'd1, 32'd2, 32'h500, 32'h10, 1'b1, 32'h510, 1'b1, 32'h510, 1'b0, 1'b0);
    fork
      applyStimulus(3'b100, 32'd2, 32'd3, 32'h600, 32'h40, 1'b1, 32'h640, 1'b1, 32'h640, 1'b0, 1'b0);
      begin
        repeat (3) begin
          @(negedge clk);
          checkValue("stall_in_ready", 64'(bus.in_ready), 64'd0);
          checkValue("stall_out_valid", 64'(bus.out_valid), 64'd1);
          checkValue("stall_redirect", 64'(bus.out_redirect_pc), 64'h510);
          checkValue("stall_taken", 64'(bus.out_taken), 64'd1);
        end
        #1 bus.out_ready = 1'b1;
      end
    join
    idle();
    repeat (3) @(negedge clk);
    checkCounts(32'd9, 32'd4);

    // Flush a held entry while the consumer accepts and a new branch arrives.
    @(negedge clk);
    #1 bus.out_ready = 1'b0;
    applyStimulus(3'b000, 32'd1, 32'd2, 32'h700, 32'h10, 1'b0, 32'h0, 1'b0, 32'h704, 1'b0, 1'b0);
    idle();
    @(negedge clk);
    checkValue("preflush_out_valid", 64'(bus.out_valid), 64'd1);
    #1;
    flush = 1'b1;
    bus.out_ready = 1'b1;
    bus.in_valid = 1'b1;
    sb.delete();
    @(negedge clk);
    checkValue("flush_out_valid", 64'(bus.out_valid), 64'd0);
    #1;
    flush = 1'b0;
    bus.in_valid = 1'b0;
    repeat (2) @(negedge clk);
    checkValue("postflush_out_valid", 64'(bus.out_valid), 64'd0);
    checkCounts(32'd9, 32'd4);

    // Saturation on the 4-bit counter build: 18 mispredicting retires.
    @(negedge clk);
    #1;
    bus4.out_ready = 1'b1;
    bus4.in_valid = 1'b1;
    repeat (18) @(negedge clk);
    #1 bus4.in_valid = 1'b0;
    repeat (3) @(negedge clk);
    checkValue("sat_branch_count", 64'(branch_count4), 64'd15);
    checkValue("sat_mispredict_count", 64'(mispredict_count4), 64'd15);

    // Asynchronous reset with a held entry.
    #1 bus.out_ready = 1'b0;
    applyStimulus(3'b100, 32'hFFFF_FFFF, 32'd1, 32'h100, 32'h20, 1'b0, 32'h0, 1'b1, 32'h120, 1'b1, 1'b0);
    idle();
    @(negedge clk);
    checkValue("prereset_out_valid", 64'(bus.out_valid), 64'd1);
    #1;
    rst_n = 1'b0;
    sb.delete();
    #1;
    checkValue("async_out_valid", 64'(bus.out_valid), 64'd0);
    checkValue("async_out_taken", 64'(bus.out_taken), 64'd0);
    checkValue("async_out_mispredict", 64'(bus.out_mispredict), 64'd0);
    checkValue("async_redirect", 64'(bus.out_redirect_pc), 64'd0);
    checkCounts(32'd0, 32'd0);
    checkValue("async_sat_branch_count", 64'(branch_count4), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    checkValue("scoreboard_empty", 64'(sb.size()), 64'd0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
